// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 single-wire reader.
//   dht11_state_t   - reader FSM states
//   FRAME_W         - captured frame width (5 bytes)
//   *_LSB           - byte field positions inside the frame
//   DEF_*           - default timing parameters
//   checksum_good() - frame checksum test (sum of the four data bytes mod 256)
package dht11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        DONE,
        ERROR
    } dht11_state_t;

    localparam int unsigned FRAME_W    = 40;
    localparam int unsigned US_CNT_W   = 16;

    localparam int unsigned RH_INT_LSB = 32;
    localparam int unsigned RH_DEC_LSB = 24;
    localparam int unsigned T_INT_LSB  = 16;
    localparam int unsigned T_DEC_LSB  = 8;
    localparam int unsigned CSUM_LSB   = 0;

    localparam int unsigned DEF_CLK_FREQ_HZ   = 50_000_000;
    localparam int unsigned DEF_START_LOW_US  = 18_000;
    localparam int unsigned DEF_TIMEOUT_US    = 100;
    localparam int unsigned DEF_BIT_THRESH_US = 40;

    function automatic logic checksum_good(input logic [FRAME_W-1:0] f);
        logic [7:0] sum;
        sum = f[RH_INT_LSB +: 8] + f[RH_DEC_LSB +: 8]
            + f[T_INT_LSB +: 8] + f[T_DEC_LSB +: 8];
        return sum == f[CSUM_LSB +: 8];
    endfunction

endpackage

// File: rtl/dht11_us_timer.sv
// dht11_us_timer: microsecond prescaler plus saturating microsecond counter.
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   clr    - synchronous clear of prescaler and counter (state entry)
//   us_cnt - microseconds elapsed since the last clear, saturating
module dht11_us_timer
    import dht11_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    output logic [US_CNT_W-1:0] us_cnt
);

    localparam int unsigned PRESCALE_W = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PRESCALE_W-1:0] PRESCALE_LOAD = PRESCALE_W'(CYCLES_PER_US - 1);

    logic [PRESCALE_W-1:0] prescale;
    logic                  tick;

    assign tick = (prescale == '0);

    // Prescaler is a down-counter; clearing reloads it so the first tick
    // after a clear lands a full microsecond later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            us_cnt   <= '0;
        end else if (clr) begin
            prescale <= PRESCALE_LOAD;
            us_cnt   <= '0;
        end else if (tick) begin
            prescale <= PRESCALE_LOAD;
            if (us_cnt != '1)
                us_cnt <= us_cnt + 1'b1;
        end else begin
            prescale <= prescale - 1'b1;
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: DHT11 single-wire protocol master.
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   start       - read request, honoured only when idle
//   dht11_data  - open-drain sensor line (driven 0 or released)
//   busy        - transaction in progress
//   frame       - last completed 40-bit frame {RH int, RH dec, T int, T dec, csum}
//   data_valid  - one-cycle strobe when frame updates
//   checksum_ok - checksum result of the current frame
//   timeout_err - one-cycle strobe when a transaction aborts
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | line released, waiting for start
// START_LOW | host holds line low for START_LOW_US
// RELEASE   | line released, waiting for sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low preamble of a data bit
// BIT_HIGH  | high phase of a data bit, its length encodes the bit
// DONE      | publish frame and checksum, strobe data_valid
// ERROR     | strobe timeout_err, frame left untouched
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
    parameter int unsigned START_LOW_US  = DEF_START_LOW_US,
    parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int unsigned BIT_THRESH_US = DEF_BIT_THRESH_US
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    inout  wire                dht11_data,
    output logic               busy,
    output logic [FRAME_W-1:0] frame,
    output logic               data_valid,
    output logic               checksum_ok,
    output logic               timeout_err
);

    localparam int unsigned CYCLES_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam logic [US_CNT_W-1:0] START_LOW_CNT  = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_CNT    = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0] BIT_THRESH_CNT = US_CNT_W'(BIT_THRESH_US);
    localparam logic [5:0]          LAST_BIT       = 6'(FRAME_W - 1);

    dht11_state_t state, state_next;

    logic [US_CNT_W-1:0] us_cnt;
    logic                us_clr;
    logic                line_meta, line_sync, line_prev;
    logic                rise, fall;
    logic                drive_low;
    logic                bit_val, timed_out;
    logic                shift_en, idx_clr, frame_ld;
    logic [FRAME_W-1:0]  shift_reg, shift_next;
    logic [5:0]          bit_idx;

    dht11_us_timer #(.CYCLES_PER_US(CYCLES_PER_US)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (us_clr),
        .us_cnt (us_cnt)
    );

    assign dht11_data = drive_low ? 1'b0 : 1'bz;

    assign rise       = line_sync & ~line_prev;
    assign fall       = ~line_sync & line_prev;
    assign bit_val    = (us_cnt > BIT_THRESH_CNT);
    assign timed_out  = (us_cnt >= TIMEOUT_CNT);
    assign us_clr     = (state_next != state);
    assign shift_next = {shift_reg[FRAME_W-2:0], bit_val};

    // Synchronizer resets to the idle-high line level so no edge is seen
    // coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            line_meta <= dht11_data;
            line_sync <= line_meta;
            line_prev <= line_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // drive_low is registered from the current state, so the pin follows
    // START_LOW one cycle late on both entry and exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drive_low   <= 1'b0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            frame       <= '0;
            checksum_ok <= 1'b0;
        end else begin
            drive_low <= (state == START_LOW);
            if (idx_clr)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 6'd1;
            if (shift_en)
                shift_reg <= shift_next;
            if (frame_ld) begin
                frame       <= shift_next;
                checksum_ok <= checksum_good(shift_next);
            end
        end
    end

    // frame is loaded on the transition into DONE so it is already stable
    // while data_valid is high. DONE and ERROR report busy low so busy falls
    // together with the result strobe.
    always_comb begin
        state_next  = state;
        shift_en    = 1'b0;
        idx_clr     = 1'b0;
        frame_ld    = 1'b0;
        busy        = 1'b1;
        data_valid  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = START_LOW;
            end
            START_LOW: begin
                if (us_cnt == START_LOW_CNT)
                    state_next = RELEASE;
            end
            RELEASE: begin
                if (timed_out)
                    state_next = ERROR;
                else if (fall)
                    state_next = RESP_LOW;
            end
            RESP_LOW: begin
                if (timed_out)
                    state_next = ERROR;
                else if (rise)
                    state_next = RESP_HIGH;
            end
            RESP_HIGH: begin
                if (timed_out) begin
                    state_next = ERROR;
                end else if (fall) begin
                    idx_clr    = 1'b1;
                    state_next = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (timed_out)
                    state_next = ERROR;
                else if (rise)
                    state_next = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (timed_out) begin
                    state_next = ERROR;
                end else if (fall) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        frame_ld   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BIT_LOW;
                    end
                end
            end
            DONE: begin
                busy       = 1'b0;
                data_valid = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                busy        = 1'b0;
                timeout_err = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dht11_reader.sv
`timescale 1ns/1ps
module tb_dht11_reader;

    localparam int CLK_HZ   = 2_000_000;
    localparam int HALF_NS  = 1_000_000_000 / CLK_HZ / 2;
    localparam int START_US = 50;
    localparam int CPU      = CLK_HZ / 1_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        model_low = 1'b0;
    wire         dht11_data;
    logic        busy, data_valid, checksum_ok, timeout_err;
    logic [39:0] frame;

    assign dht11_data = model_low ? 1'b0 : 1'bz;
    pullup (dht11_data);

    always #(HALF_NS) clk = ~clk;

    dht11_reader #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .START_LOW_US  (START_US),
        .TIMEOUT_US    (100),
        .BIT_THRESH_US (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dht11_data  (dht11_data),
        .busy        (busy),
        .frame       (frame),
        .data_valid  (data_valid),
        .checksum_ok (checksum_ok),
        .timeout_err (timeout_err)
    );

    typedef struct {
        bit          is_err;
        logic [39:0] frame;
        bit          ck;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          host_pulses = 0;
    bit          host_prev = 1'b0;
    bit          host_now;
    logic [39:0] ref_frame = '0;
    bit          ref_ck = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        n_tests++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic int urange(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Reference checksum: plain integer sum of the four data bytes.
    function automatic bit ck_ref(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    // Monitor: counts host-driven low pulses and scores every result strobe.
    always @(negedge clk) begin
        exp_t e;
        host_now = (dht11_data === 1'b0) && !model_low;
        if (host_now && !host_prev)
            host_pulses++;
        host_prev = host_now;
        if (reset && (data_valid || timeout_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {data_valid, timeout_err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {data_valid, timeout_err}, e.is_err ? 2'b01 : 2'b10);
                check("frame", frame, e.frame);
                check("checksum_ok", checksum_ok, e.ck);
                check("busy_at_event", busy, 1'b0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issue start and measure how many cycles the host holds the line low.
    task automatic host_phase(output int low_cycles);
        int guard;
        guard = 0;
        low_cycles = 0;
        pulse_start();
        while (dht11_data !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (dht11_data === 1'b0 && low_cycles < 1000) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    // Sensor model: response then nbits data bits. hi0/hi1 <= 0 picks a
    // random nominal high time. A full frame ends with the closing low pulse.
    task automatic sensor_reply(input logic [39:0] data, input int nbits,
                                input int hi0, input int hi1, input bit poke);
        int hi;
        #(urange(20, 40) * 1000);
        model_low = 1'b1;
        #(80_000);
        model_low = 1'b0;
        #(80_000);
        for (int i = 0; i < nbits; i++) begin
            model_low = 1'b1;
            if (poke && i == 5)
                fork pulse_start(); join_none
            #(urange(45, 55) * 1000);
            model_low = 1'b0;
            if (data[39-i])
                hi = (hi1 > 0) ? hi1 : urange(65, 75);
            else
                hi = (hi0 > 0) ? hi0 : urange(22, 30);
            #(hi * 1000);
        end
        if (nbits == 40) begin
            model_low = 1'b1;
            #(50_000);
            model_low = 1'b0;
        end
    endtask

    task automatic wait_drain(input int limit, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check("events_within_bound", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_exp(input bit is_err, input logic [39:0] f);
        exp_t e;
        e.is_err = is_err;
        if (!is_err) begin
            ref_frame = f;
            ref_ck    = ck_ref(f);
        end
        e.frame = ref_frame;
        e.ck    = ref_ck;
        exp_q.push_back(e);
    endtask

    task automatic run_frame(input logic [39:0] data, input int hi0, input int hi1, input bit poke);
        int lc, cyc;
        push_exp(1'b0, data);
        host_phase(lc);
        check_range("start_low_cycles", lc, START_US*CPU, START_US*CPU + 2);
        sensor_reply(data, 40, hi0, hi1, poke);
        wait_drain(1000, cyc);
        @(negedge clk);
        check("busy_after_frame", busy, 1'b0);
    endtask

    function automatic logic [39:0] rand_frame(input bit good);
        logic [39:0] d;
        int s;
        d[39:8] = $urandom();
        s = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
        d[7:0] = good ? 8'(s) : 8'($urandom());
        return d;
    endfunction

    initial begin
        int lc, cyc, hp0;
        logic [39:0] d;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_frame", frame, 40'h0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_checksum_ok", checksum_ok, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_line_released", dht11_data, 1'b1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(40'h37_00_18_00_4F, 26, 70, 1'b0);
        run_frame(40'h37_00_18_00_50, 26, 70, 1'b0);

        // Silent sensor: abort 100 us after release, frame retained.
        push_exp(1'b1, '0);
        host_phase(lc);
        check_range("noresp_start_low_cycles", lc, START_US*CPU, START_US*CPU + 2);
        wait_drain(1000, cyc);
        check_range("noresp_timeout_cycles", cyc, 100*CPU - 4, 100*CPU + 6);
        @(negedge clk);
        check("noresp_busy", busy, 1'b0);

        // Truncated after 20 bits, line left high.
        push_exp(1'b1, '0);
        host_phase(lc);
        sensor_reply(rand_frame(1'b1), 20, -1, -1, 1'b0);
        wait_drain(1000, cyc);

        // Threshold boundary: 40 us decodes 0, 42 us decodes 1.
        run_frame(40'h37_00_18_00_4F, 40, 42, 1'b0);

        for (int k = 0; k < 2; k++)
            run_frame(rand_frame($urandom_range(1, 0) == 1), -1, -1, 1'b0);

        // Reset while the host drives the start pulse: line released at once.
        pulse_start();
        repeat (20) @(negedge clk);
        check("host_drive_low", dht11_data, 1'b0);
        reset = 1'b0;
        #1;
        check("async_release", dht11_data, 1'b1);
        check("async_busy", busy, 1'b0);
        ref_frame = '0;
        ref_ck = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-frame at bit 10.
        host_phase(lc);
        d = rand_frame(1'b1);
        sensor_reply(d, 10, -1, -1, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_line", dht11_data, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_frame", frame, 40'h0);
        check("midrst_data_valid", data_valid, 1'b0);
        check("midrst_checksum_ok", checksum_ok, 1'b0);
        check("midrst_timeout_err", timeout_err, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);

        // start pulsed while busy is ignored: exactly one host pulse.
        hp0 = host_pulses;
        run_frame(rand_frame(1'b1), -1, -1, 1'b1);
        repeat (300) @(negedge clk);
        check("one_txn_per_start", host_pulses - hp0, 1);
        check("idle_after_busy_start", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
